// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the single-cycle core:
//               field widths, opcode encoding, HALT word, fetch FSM states
//               and the branch-target table produced by the assembler flow.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int OP_W      = 3;
  localparam int LUT_IDX_W = 5;
  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;

  typedef enum logic [OP_W-1:0] {
    ADD  = 3'b000,
    ROR  = 3'b001,
    NAND = 3'b010,
    LDR  = 3'b011,
    STR  = 3'b100,
    MOV  = 3'b101,
    BNE  = 3'b110,
    SET  = 3'b111
  } opcode_t;

  // All-ones word reserved as the program terminator.
  localparam logic [INSTR_W-1:0] HALT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Branch targets, indexed by instr[4:0]. Regenerated by the assembler.
  localparam logic [PC_W-1:0] BRANCH_LUT [0:LUT_DEPTH-1] = '{
    10'd0,   10'd12,  10'd40,  10'd100, 10'd3,   10'd9,   10'd20,  10'd500,
    10'd1023,10'd2,   10'd17,  10'd33,  10'd64,  10'd128, 10'd256, 10'd511,
    10'd7,   10'd14,  10'd21,  10'd28,  10'd35,  10'd42,  10'd49,  10'd56,
    10'd63,  10'd70,  10'd77,  10'd84,  10'd91,  10'd98,  10'd105, 10'd112
  };

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word == HALT);
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut
// Description : Combinational branch-target ROM, 2^LUT_IDX_W entries of
//               PC_W bits, contents taken from core_pkg::BRANCH_LUT.
// Ports       : i_idx    [LUT_IDX_W-1:0]  table index (instr[4:0])
//               o_target [PC_W-1:0]       branch target address
// Revision    : 1.0 - initial release
// ============================================================================
module branch_lut
  import core_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]      o_target
);

  assign o_target = BRANCH_LUT[i_idx];

endmodule : branch_lut
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch front end of the single-cycle core. Holds the PC,
//               addresses instruction memory, issues one instruction per
//               cycle and redirects through the branch-target table when the
//               decoder signals Branch and the ALU reports not-equal.
// Ports       : clk, reset        clock, synchronous active-high reset
//               start             run program from address 0 (IDLE/DONE)
//               stall             hold PC and instruction this cycle
//               branch, ne_flag   decoder Branch, ALU not-equal
//               imem_data         instruction memory read data
//               imem_addr, pc     memory address / program counter
//               instr, opcode     issued instruction and its opcode field
//               issue_valid, done live-instruction flag, program finished
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import core_pkg::*;
#(
  parameter int PROG_LEN = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch,
  input  logic               ne_flag,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    opcode,
  output logic               issue_valid,
  output logic               done
);

  localparam logic [PC_W-1:0] c_last_pc = PC_W'(PROG_LEN - 1);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;
  logic               r_done;
  logic [INSTR_W-1:0] w_instr;
  logic [PC_W-1:0]    w_target;
  logic               w_taken;

  // r_valid is high exactly while in RUN, so it gates the memory word.
  assign w_instr = r_valid ? imem_data : '0;
  assign w_taken = branch && ne_flag;

  branch_lut u_branch_lut (
    .i_idx    (w_instr[LUT_IDX_W-1:0]),
    .o_target (w_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_pc <= '0;
          if (start) begin
            r_state <= RUN;
            r_valid <= 1'b1;
          end
        end

        RUN: begin
          // Priority: stall > HALT > taken branch > end of program > pc+1.
          // A taken branch at the last address still redirects.
          if (stall) begin
            r_pc <= r_pc;
          end else if (is_halt(w_instr)) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_taken) begin
            r_pc <= w_target;
          end else if (r_pc == c_last_pc) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end

        DONE: begin
          // Restart goes straight back to RUN without an IDLE cycle.
          if (start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_pc    <= '0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = w_instr;
  assign opcode      = w_instr[INSTR_W-1 -: OP_W];
  assign issue_valid = r_valid;
  assign done        = r_done;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Vector table for reset
//               and a straight-line run, then directed sequences for
//               branches, stalls, end of program, restart and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic       clk;
  logic       reset, start, stall, branch, ne_flag;

  logic [8:0] mem1 [0:1023];
  logic [8:0] mem2 [0:15];

  logic [8:0] imem_data1, imem_data2;
  logic [9:0] imem_addr1, imem_addr2, pc1, pc2;
  logic [8:0] instr1, instr2;
  logic [2:0] opcode1, opcode2;
  logic       valid1, valid2, done1, done2;

  assign imem_data1 = mem1[imem_addr1];
  assign imem_data2 = mem2[imem_addr2[3:0]];

  instr_fetch #(.PROG_LEN(1024)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch(branch), .ne_flag(ne_flag), .imem_data(imem_data1),
    .imem_addr(imem_addr1), .pc(pc1), .instr(instr1), .opcode(opcode1),
    .issue_valid(valid1), .done(done1)
  );

  instr_fetch #(.PROG_LEN(16)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch(branch), .ne_flag(ne_flag), .imem_data(imem_data2),
    .imem_addr(imem_addr2), .pc(pc2), .instr(instr2), .opcode(opcode2),
    .issue_valid(valid2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic       stl;
    logic       br;
    logic       ne;
    logic [9:0] pc;
    logic       valid;
    logic       done;
    logic [8:0] instr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic sl,
                     input logic b, input logic n);
    reset = r; start = s; stall = sl; branch = b; ne_flag = n;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; ne_flag = 1'b0;

    for (int i = 0; i < 1024; i++) mem1[i] = 9'h01A;
    for (int i = 0; i < 16; i++)   mem2[i] = 9'h01A;
    mem1[0] = 9'h01A;  // ADD
    mem1[1] = 9'h141;  // MOV
    mem1[2] = 9'h102;  // STR
    mem1[3] = 9'h1FF;  // HALT

    //          rst st  stl br  ne  pc      vld done instr
    vecs[0] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0,1'b0,1'b0,9'h000};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0,1'b0,1'b0,9'h000};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,10'd0,1'b1,1'b0,9'h01A};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0,10'd1,1'b1,1'b0,9'h141};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'd2,1'b1,1'b0,9'h102};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'd3,1'b1,1'b0,9'h1FF};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'd3,1'b0,1'b1,9'h000};
    vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,10'd3,1'b0,1'b1,9'h000};

    for (int i = 0; i < 8; i++) begin
      logic [8:0] e_instr;
      cyc(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].br, vecs[i].ne);
      e_instr = vecs[i].instr;
      chk($sformatf("vec%0d pc", i),     pc1,        vecs[i].pc);
      chk($sformatf("vec%0d addr", i),   imem_addr1, vecs[i].pc);
      chk($sformatf("vec%0d valid", i),  valid1,     vecs[i].valid);
      chk($sformatf("vec%0d done", i),   done1,      vecs[i].done);
      chk($sformatf("vec%0d instr", i),  instr1,     e_instr);
      chk($sformatf("vec%0d opcode", i), opcode1,    e_instr[8:6]);
    end

    // Branch program: BNE idx2 at 5 (lut->40), BNE idx1 at 7 (lut->12).
    for (int i = 0; i < 1024; i++) mem1[i] = 9'h01A;
    mem1[5]  = 9'h182;
    mem1[7]  = 9'h181;
    mem1[12] = 9'h1FF;
    mem1[40] = 9'h1FF;

    cyc(0, 1, 0, 0, 0);
    run(5);
    chk("br_at5 pc", pc1, 10'd5);
    chk("br_at5 opcode", opcode1, 3'b110);
    cyc(0, 0, 0, 1, 1);
    chk("br_taken pc", pc1, 10'd40);
    chk("br_taken valid", valid1, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("halt40 done", done1, 1'b1);
    chk("halt40 pc", pc1, 10'd40);

    cyc(1, 1, 0, 0, 0);
    chk("rst_done pc", pc1, 10'd0);
    chk("rst_done done", done1, 1'b0);

    cyc(0, 1, 0, 0, 0);
    run(5);
    cyc(0, 0, 0, 1, 0);
    chk("br_not_taken pc", pc1, 10'd6);
    cyc(0, 0, 0, 0, 0);
    chk("at7 pc", pc1, 10'd7);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1);
      chk($sformatf("stall%0d pc", i), pc1, 10'd7);
      chk($sformatf("stall%0d instr", i), instr1, 9'h181);
    end
    cyc(0, 0, 0, 1, 1);
    chk("after_stall pc", pc1, 10'd12);
    cyc(0, 0, 1, 0, 0);
    chk("stall_halt pc", pc1, 10'd12);
    chk("stall_halt valid", valid1, 1'b1);
    chk("stall_halt done", done1, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("halt12 done", done1, 1'b1);
    chk("halt12 valid", valid1, 1'b0);

    // Reset in the middle of a run.
    cyc(0, 1, 0, 0, 0);
    run(9);
    chk("midrun pc", pc1, 10'd9);
    cyc(1, 1, 1, 0, 0);
    chk("midrst pc", pc1, 10'd0);
    chk("midrst valid", valid1, 1'b0);
    chk("midrst instr", instr1, 9'h000);
    run(2);
    chk("idle_hold pc", pc1, 10'd0);
    chk("idle_hold valid", valid1, 1'b0);
    cyc(0, 1, 0, 0, 0);
    chk("idle_start valid", valid1, 1'b1);
    chk("idle_start pc", pc1, 10'd0);

    // End of program on the 16-word instance, restart, branch at last address.
    mem2[15] = 9'h189;  // BNE idx9 -> lut 2
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    run(15);
    chk("eop pc15", pc2, 10'd15);
    chk("eop valid", valid2, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("eop done", done2, 1'b1);
    chk("eop hold pc", pc2, 10'd15);
    cyc(0, 1, 0, 0, 0);
    chk("restart pc", pc2, 10'd0);
    chk("restart done", done2, 1'b0);
    chk("restart valid", valid2, 1'b1);
    run(15);
    cyc(0, 0, 0, 1, 1);
    chk("last_br pc", pc2, 10'd2);
    chk("last_br valid", valid2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the single-cycle core: holds the program counter, reads instruction memory and issues one 9-bit instruction per cycle to the control decoder.
- Its 3-bit opcode field, instr[8:6], feeds the decoder's instr input.
- Consumes the decoder's Branch output and the ALU not-equal flag to redirect the PC through a branch-target lookup table.
- Runs a start/done handshake with the testbench or top level.

Parameters:
- PC_W, 10, program counter width in bits.
- INSTR_W, 9, instruction word width in bits.
- OP_W, 3, opcode field width (instr[8:6]).
- LUT_IDX_W, 5, branch-target index width (instr[4:0]).
- PROG_LEN, 1024, number of valid instruction addresses; the last address is PROG_LEN-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run the program from address 0.
- stall  in  1  hold the current PC and instruction for one cycle.
- branch  in  1  Branch output from the control decoder for the current instruction.
- ne_flag  in  1  ALU result: operands not equal.
- imem_data  in  INSTR_W  instruction memory read data; combinational read at imem_addr.
- imem_addr  out  PC_W  instruction memory address; equals pc.
- pc  out  PC_W  current program counter.
- instr  out  INSTR_W  issued instruction; equals imem_data while RUN, else 0.
- opcode  out  OP_W  instr[8:6]; drives the decoder.
- issue_valid  out  1  high when instr is a live instruction.
- done  out  1  program finished.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE, pc=0, done=0, issue_valid=0, instr=0.
  - Reset has priority over every other input, including start in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 sampled -> next cycle RUN with pc=0.
  - Otherwise stay in IDLE; pc holds 0.
- RUN:
  - issue_valid=1; instr=imem_data.
  - Next-PC priority, evaluated each edge:
    1. stall=1: pc holds.
    2. instr==HALT (9'h1FF): go to DONE; pc holds.
    3. branch=1 and ne_flag=1: pc <= zero-extended branch_lut[instr[4:0]].
    4. pc==PROG_LEN-1: go to DONE; pc holds. Running off the end is treated as a halt; the PC never wraps.
    5. Otherwise pc <= pc+1.
  - A branch with ne_flag=0 falls through to pc+1.
  - A branch at pc==PROG_LEN-1 is taken if its condition holds.
  - A stall with HALT present delays the halt until the first non-stall cycle.
  - start is ignored while in RUN.
- DONE:
  - done=1, issue_valid=0, instr=0, pc holds its last value.
  - start=1 -> next cycle RUN with pc=0 and done=0. The program restarts; no pass through IDLE.
- Latency:
  - start accepted -> first instruction issued one cycle later.
  - Taken branch -> target issued on the next cycle; no bubble, because the decoder and ALU are combinational in the same cycle.
- Width rules:
  - The LUT entry is PC_W wide.
  - pc+1 is computed in PC_W bits; no overflow is possible, because the end-of-program rule fires first.
- Reset mid-RUN or mid-DONE: next cycle IDLE, pc=0, done=0, regardless of stall or start.

Decomposition:
- Shared package core_pkg:
  - Opcode enum: ADD=3'b000, ROR=3'b001, NAND=3'b010, LDR=3'b011, STR=3'b100, MOV=3'b101, BNE=3'b110, SET=3'b111.
  - HALT constant 9'h1FF.
  - FSM state enum fetch_state_t {IDLE, RUN, DONE}.
  - Width constants PC_W, INSTR_W, OP_W, LUT_IDX_W.
- One sub-module, branch_lut:
  - Combinational ROM of 2^LUT_IDX_W entries, each PC_W bits.
  - Index input, target output.
  - Contents are set by the assembler flow and live in the package as a constant array.

Test Plan:
- Reset sequencing: reset=1 for 2 cycles with start=1 -> pc=0, done=0, issue_valid=0. Release reset with start=1 -> next cycle RUN, pc=0, issue_valid=1.
- Straight-line run: memory 0..3 = ADD, MOV, STR, HALT; pulse start -> pc 0,1,2,3 on consecutive cycles; done=1 from the cycle after HALT; pc stays 3.
- Branch taken and not taken: pc=5 holds BNE with instr[4:0]=2 and lut[2]=40.
  - ne_flag=1, branch=1 -> next pc=40.
  - Repeat with ne_flag=0 -> next pc=6.
- Stall priority: stall=1 for 3 cycles at pc=7, with a taken branch present -> pc stays 7 all 3 cycles; after stall drops, next pc=lut target.
- End of program and restart: PROG_LEN=16 with no HALT -> DONE after issuing pc=15. Assert start in DONE -> next cycle pc=0, done=0, issue_valid=1.
- Reset mid-run: at pc=9 in RUN, assert reset for 1 cycle -> next cycle IDLE, pc=0, issue_valid=0; the design stays idle until start.
